buzzer_round_arbiter: RTL and testbench
=======================================

// Module: buzzer_round_arbiter
// PURPOSE
//  Sequences one quiz round among 4 player controllers. Arms after a start delay,
//  grants the answer to the first eligible buzzer (rotating-priority tie-break),
//  runs a timed answer window and locks out wrong/timed-out players.
//  Sits between the debounced controller buttons and the game CPU/MMIO layer.
// PARAMETERS
//  CNT_W            28           width of shared cycle counter
//  ARM_DELAY_CYCLES 50_000_000   ARMING duration (1 s @ 50 MHz); >=1
//  ANSWER_CYCLES    250_000_000  answer window (5 s @ 50 MHz); >=1, < 2**CNT_W
// PORTS
//  clk           in   1  system clock, 50 MHz
//  rst           in   1  synchronous, active-low reset
//  btn_req       in   4  debounced player buttons, level, bit i = player i+1
//  start_round   in   1  pulse: begin round; honoured only in IDLE/DONE
//  judge_correct in   1  pulse: current answer correct; honoured only in ANSWER
//  judge_wrong   in   1  pulse: current answer wrong; honoured only in ANSWER
//  state         out  3  0 IDLE,1 ARMING,2 OPEN,3 ANSWER,4 DONE
//  winner_valid  out  1  a player currently holds/held the answer
//  winner_id     out  2  player index of current/last grant
//  lockout       out  4  per-player lockout for this round
//  timeout       out  1  one-cycle pulse when answer window expires
// BEHAVIOUR
//  - All outputs and state registered. Reset (rst=0 at posedge): state=IDLE,
//    winner_valid=0, winner_id=0, lockout=0, timeout=0, counter=0, prio_ptr=0,
//    btn_q=0. Reset mid-round aborts with no grant.
//  - Edge detect: btn_q <= btn_req every cycle; rise = btn_req & ~btn_q. Held
//    buttons never grant; only rising edges count.
//  - IDLE/DONE: start_round -> ARMING; lockout<=0, counter<=0, winner_valid<=0.
//    In DONE, winner_valid/winner_id keep their last value until then.
//  - ARMING: counter increments; at counter==ARM_DELAY_CYCLES-1 -> OPEN, counter<=0.
//  - OPEN: elig = rise & ~lockout. If elig!=0, pick first set bit searching
//    prio_ptr, prio_ptr+1, ... mod 4; same edge: winner_id<=pick, winner_valid<=1,
//    prio_ptr<=pick+1 mod 4, counter<=0, state<=ANSWER. Grant latency: outputs
//    visible the cycle after the first sample where btn_req is high.
//    If lockout==4'hF -> DONE with winner_valid=0.
//  - ANSWER: counter increments. Priority: judge_correct > judge_wrong > timeout.
//    correct -> DONE, winner_valid stays 1. wrong, or counter==ANSWER_CYCLES-1
//    (timeout<=1 for one cycle in the timeout case only) -> lockout[winner_id]<=1,
//    winner_valid<=0, counter<=0; -> DONE if new lockout==4'hF, else OPEN.
//    Buttons ignored in ANSWER (btn_q still tracks so no stale edges later).
//  - Pulses on start_round/judge_* in non-honouring states are ignored.
//  - Counter never wraps: it is cleared at every state entry and compared exactly.
// CONFIGURATION
//  FALSE_START_PENALTY_EN defined: a rise on btn_req[i] during ARMING sets
//    lockout[i]; that player is ineligible for the rest of the round.
//  Not defined: buttons in ARMING are ignored; no lockout is set before OPEN.
// TESTING (ARM_DELAY_CYCLES=4, ANSWER_CYCLES=8)
//  1 reset: rst=0 two cycles mid-ANSWER -> state=0, winner_valid=0, lockout=0.
//  2 start_round; after 4 cycles state=2; btn_req=4'b0100 -> next cycle
//    state=3, winner_id=2, winner_valid=1; judge_correct -> state=4, valid=1.
//  3 tie: prio_ptr=0, btn_req 0->4'b1010 same cycle -> winner_id=1;
//    next round same tie -> winner_id=3 (prio_ptr=2).
//  4 wrong: winner 1, judge_wrong -> lockout=4'b0010, state=2; player1
//    re-press ignored; player 3 press -> winner_id=3.
//  5 timeout: grant then no judge for 8 cycles -> timeout pulse 1 cycle,
//    lockout bit set; four successive timeouts -> state=4, winner_valid=0.
//  6 macro on: btn_req[0] rises in ARMING -> lockout=4'b0001, later press ignored;
//    macro off: same stimulus -> lockout=0, press in OPEN grants player 0.

Source files
------------

// File: rtl/buzzer_round_arbiter.sv
// Quiz-round buzzer arbiter for 4 players: arm delay, rotating-priority grant,
// timed answer window with lockout. Optional macro: FALSE_START_PENALTY_EN.

module buzzer_lane (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic rise
);
  logic btn_q;

  always_ff @(posedge clk) begin
    if (!rst) btn_q <= 1'b0;
    else      btn_q <= btn;
  end

  assign rise = btn & ~btn_q;
endmodule

module buzzer_round_arbiter #(
  parameter int CNT_W            = 28,
  parameter int ARM_DELAY_CYCLES = 50_000_000,
  parameter int ANSWER_CYCLES    = 250_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn_req,
  input  logic       start_round,
  input  logic       judge_correct,
  input  logic       judge_wrong,
  output logic [2:0] state,
  output logic       winner_valid,
  output logic [1:0] winner_id,
  output logic [3:0] lockout,
  output logic       timeout
);
  localparam int NUM_PLAYERS = 4;
  localparam logic [CNT_W-1:0] ARM_LAST = CNT_W'(ARM_DELAY_CYCLES - 1);
  localparam logic [CNT_W-1:0] ANS_LAST = CNT_W'(ANSWER_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARMING = 3'd1,
    S_OPEN   = 3'd2,
    S_ANSWER = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t           cur;
  logic [CNT_W-1:0] counter;
  logic [1:0]       prio_ptr;
  logic [3:0]       rise;
  logic [3:0]       elig;
  logic [3:0]       lock_next;
  logic [1:0]       pick;
  logic [1:0]       idx;
  logic             pick_vld;

  for (genvar i = 0; i < NUM_PLAYERS; i++) begin : g_lane
    buzzer_lane u_lane (
      .clk  (clk),
      .rst  (rst),
      .btn  (btn_req[i]),
      .rise (rise[i])
    );
  end

  assign elig      = rise & ~lockout;
  assign lock_next = lockout | (4'b0001 << winner_id);
  assign state     = cur;

  // Walk the priority ring from the far end so the nearest eligible player wins.
  always_comb begin
    pick     = prio_ptr;
    pick_vld = 1'b0;
    idx      = prio_ptr;
    for (int j = NUM_PLAYERS - 1; j >= 0; j--) begin
      idx = prio_ptr + 2'(j);
      if (elig[idx]) begin
        pick     = idx;
        pick_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cur          <= S_IDLE;
      winner_valid <= 1'b0;
      winner_id    <= 2'd0;
      lockout      <= 4'd0;
      timeout      <= 1'b0;
      counter      <= '0;
      prio_ptr     <= 2'd0;
    end else begin
      timeout <= 1'b0;
      case (cur)
        S_IDLE, S_DONE: begin
          if (start_round) begin
            cur          <= S_ARMING;
            lockout      <= 4'd0;
            counter      <= '0;
            winner_valid <= 1'b0;
          end
        end
        S_ARMING: begin
`ifdef FALSE_START_PENALTY_EN
          lockout <= lockout | rise;
`endif
          if (counter == ARM_LAST) begin
            cur     <= S_OPEN;
            counter <= '0;
          end else begin
            counter <= counter + CNT_W'(1);
          end
        end
        S_OPEN: begin
          if (&lockout) begin
            cur          <= S_DONE;
            winner_valid <= 1'b0;
          end else if (pick_vld) begin
            winner_id    <= pick;
            winner_valid <= 1'b1;
            prio_ptr     <= pick + 2'd1;
            counter      <= '0;
            cur          <= S_ANSWER;
          end
        end
        S_ANSWER: begin
          counter <= counter + CNT_W'(1);
          if (judge_correct) begin
            cur <= S_DONE;
          end else if (judge_wrong || counter == ANS_LAST) begin
            timeout      <= ~judge_wrong;
            lockout      <= lock_next;
            winner_valid <= 1'b0;
            counter      <= '0;
            cur          <= (&lock_next) ? S_DONE : S_OPEN;
          end
        end
        default: cur <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_buzzer_round_arbiter.sv
// Bench for buzzer_round_arbiter: directed scenarios plus random stimulus,
// all checked every cycle against a behavioural round model.

module tb_buzzer_round_arbiter;
  localparam int ARM = 4;
  localparam int ANS = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] btn_req = 4'd0;
  logic       start_round = 1'b0;
  logic       judge_correct = 1'b0;
  logic       judge_wrong = 1'b0;
  logic [2:0] state;
  logic       winner_valid;
  logic [1:0] winner_id;
  logic [3:0] lockout;
  logic       timeout;

  buzzer_round_arbiter #(.CNT_W(28), .ARM_DELAY_CYCLES(ARM), .ANSWER_CYCLES(ANS)) dut (
    .clk(clk), .rst(rst), .btn_req(btn_req), .start_round(start_round),
    .judge_correct(judge_correct), .judge_wrong(judge_wrong),
    .state(state), .winner_valid(winner_valid), .winner_id(winner_id),
    .lockout(lockout), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Round model: phase number, elapsed time measured from the cycle a phase began.
  int       cyc = 0;
  int       m_state = 0;
  bit       m_valid = 0;
  int       m_id = 0;
  bit [3:0] m_lock = 0;
  bit [3:0] m_prev = 0;
  bit       m_to = 0;
  int       m_ptr = 0;
  int       m_entry = 0;

  task automatic model_step();
    bit [3:0] rise;
    bit [3:0] elig;
    int p;
    cyc++;
    m_to = 0;
    if (!rst) begin
      m_state = 0; m_valid = 0; m_id = 0; m_lock = 0; m_ptr = 0; m_prev = 0;
      return;
    end
    rise = btn_req & ~m_prev;
    m_prev = btn_req;
    case (m_state)
      0, 4: if (start_round) begin
        m_state = 1; m_lock = 0; m_valid = 0; m_entry = cyc;
      end
      1: begin
`ifdef FALSE_START_PENALTY_EN
        m_lock |= rise;
`endif
        if (cyc - m_entry == ARM) m_state = 2;
      end
      2: begin
        elig = rise & ~m_lock;
        if (m_lock == 4'hF) begin
          m_state = 4; m_valid = 0;
        end else if (elig != 0) begin
          p = m_ptr;
          for (int j = 0; j < 4; j++) begin
            p = (m_ptr + j) % 4;
            if (elig[p]) break;
          end
          m_id = p; m_valid = 1; m_ptr = (p + 1) % 4; m_state = 3; m_entry = cyc;
        end
      end
      3: begin
        if (judge_correct) m_state = 4;
        else if (judge_wrong || (cyc - m_entry == ANS)) begin
          m_to = !judge_wrong;
          m_lock[m_id] = 1;
          m_valid = 0;
          m_state = (m_lock == 4'hF) ? 4 : 2;
        end
      end
      default: m_state = 0;
    endcase
  endtask

  task automatic compare();
    tests++;
    if (state !== 3'(m_state) || winner_valid !== m_valid || winner_id !== 2'(m_id) ||
        lockout !== m_lock || timeout !== m_to) begin
      fails++;
      $display("FAIL model cyc=%0d got st=%0d v=%b id=%0d lk=%b to=%b want st=%0d v=%b id=%0d lk=%b to=%b",
               cyc, state, winner_valid, winner_id, lockout, timeout,
               m_state, m_valid, m_id, m_lock, m_to);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic chk(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s got=%0d want=%0d", name, got, exp);
    end
  endtask

  task automatic start_and_open();
    start_round = 1'b1;
    cycle();
    start_round = 1'b0;
    repeat (ARM) cycle();
  endtask

  task automatic judge_ok();
    judge_correct = 1'b1;
    cycle();
    judge_correct = 1'b0;
  endtask

  initial begin
    repeat (2) cycle();
    rst = 1'b1;
    cycle();
    chk("reset_state", int'(state), 0);
    chk("reset_lockout", int'(lockout), 0);

    // tie-break with prio_ptr at 0, then at 2
    start_and_open();
    chk("armed_open", int'(state), 2);
    btn_req = 4'b1010; cycle(); btn_req = 4'd0;
    chk("tie1_id", int'(winner_id), 1);
    chk("tie1_state", int'(state), 3);
    judge_ok();
    start_and_open();
    btn_req = 4'b1010; cycle(); btn_req = 4'd0;
    chk("tie2_id", int'(winner_id), 3);
    judge_ok();

    // single grant and correct answer
    start_and_open();
    btn_req = 4'b0100; cycle(); btn_req = 4'd0;
    chk("grant_id", int'(winner_id), 2);
    chk("grant_valid", int'(winner_valid), 1);
    judge_ok();
    chk("correct_state", int'(state), 4);
    chk("correct_valid", int'(winner_valid), 1);

    // wrong answer locks the player out
    start_and_open();
    btn_req = 4'b0010; cycle(); btn_req = 4'd0;
    judge_wrong = 1'b1; cycle(); judge_wrong = 1'b0;
    chk("wrong_lockout", int'(lockout), 4'b0010);
    chk("wrong_state", int'(state), 2);
    btn_req = 4'b0010; cycle();
    chk("locked_press", int'(state), 2);
    btn_req = 4'b1010; cycle(); btn_req = 4'd0;
    chk("regrant_id", int'(winner_id), 3);
    judge_ok();

    // four successive timeouts end the round
    start_and_open();
    for (int p = 0; p < 4; p++) begin
      btn_req = 4'(1 << p); cycle(); btn_req = 4'd0;
      chk("to_grant_id", int'(winner_id), p);
      repeat (ANS - 1) cycle();
      chk("to_early", int'(timeout), 0);
      cycle();
      chk("to_pulse", int'(timeout), 1);
      chk("to_lock_bit", int'(lockout[p]), 1);
      cycle();
      chk("to_pulse_end", int'(timeout), 0);
    end
    chk("all_out_state", int'(state), 4);
    chk("all_out_valid", int'(winner_valid), 0);

    // reset in the middle of an answer
    start_and_open();
    btn_req = 4'b1000; cycle(); btn_req = 4'd0;
    cycle();
    chk("pre_reset_state", int'(state), 3);
    rst = 1'b0; cycle(); cycle(); rst = 1'b1;
    chk("midrst_state", int'(state), 0);
    chk("midrst_valid", int'(winner_valid), 0);
    chk("midrst_lockout", int'(lockout), 0);

    // press during arming
    start_round = 1'b1; cycle(); start_round = 1'b0;
    btn_req = 4'b0001; cycle(); btn_req = 4'd0;
    repeat (ARM - 1) cycle();
    chk("arm_open", int'(state), 2);
    btn_req = 4'b0001; cycle(); btn_req = 4'd0;
`ifdef FALSE_START_PENALTY_EN
    chk("false_start_lock", int'(lockout), 4'b0001);
    chk("false_start_ignored", int'(state), 2);
`else
    chk("no_penalty_lock", int'(lockout), 0);
    chk("no_penalty_grant", int'(state), 3);
    chk("no_penalty_id", int'(winner_id), 0);
`endif

    // random traffic
    for (int n = 0; n < 4000; n++) begin
      rst           = ($urandom_range(0, 299) != 0);
      start_round   = ($urandom_range(0, 5) == 0);
      judge_correct = ($urandom_range(0, 13) == 0);
      judge_wrong   = ($urandom_range(0, 9) == 0);
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 5) == 0) btn_req[b] = ~btn_req[b];
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
